dmem_dual_responder: RTL

Data-memory responder serving the pipeline's two load/store initiators: the integer LSU port (lw/sw) and the FP LSU port (flw/fsw). It accepts valid/ready requests, arbitrates between the ports and models a parameterised access latency. It returns read data or an error flag with a per-port response pulse. It replaces the stall-based integer/FP conflict handling in the memory stage with an explicit arbitrated handshake.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_rr_arbiter.sv | 34 +++
 rtl/dmem_dual_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the dual-port data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_INT = 1'b0;
    localparam logic PORT_FP  = 1'b1;

    localparam logic [1:0] WORD_OFS_MASK = 2'b11;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// rtl/dmem_rr_arbiter.sv - FP-priority two-port arbiter with integer starvation guard
module dmem_rr_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_int,
    input  logic req_fp,
    output logic grant_int,
    output logic grant_fp
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] fp_win_cnt;
    logic          force_int;

    // After MAX_WAIT consecutive FP wins over a waiting integer request, integer wins once.
    assign force_int = (fp_win_cnt == CW'(MAX_WAIT));
    assign grant_fp  = en && req_fp && !(req_int && force_int);
    assign grant_int = en && req_int && !grant_fp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_win_cnt <= '0;
        end else if (grant_int) begin
            fp_win_cnt <= '0;
        end else if (grant_fp) begin
            fp_win_cnt <= req_int ? fp_win_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/dmem_dual_responder.sv
// rtl/dmem_dual_responder.sv - arbitrated integer/FP load-store responder with fixed access latency
module dmem_dual_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int LATENCY  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        i_req_ready,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_rdata,
    output logic        i_resp_err,
    input  logic        f_req_valid,
    input  logic        f_req_write,
    input  logic [31:0] f_req_addr,
    input  logic [31:0] f_req_wdata,
    output logic        f_req_ready,
    output logic        f_resp_valid,
    output logic [31:0] f_resp_rdata,
    output logic        f_resp_err,
    output logic        busy
);

    localparam int IW = idx_width(DEPTH);

    state_t        state;
    logic [2:0]    lat_cnt;
    logic          op_write;
    logic          op_port;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic          grant_int;
    logic          grant_fp;
    logic          arb_en;
    logic [IW-1:0] op_idx;
    logic          op_err;
    logic          access_done;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic [31:0]   mem [DEPTH];

    // Gating with rst_n keeps the ready outputs at 0 while reset is held.
    assign arb_en = (state == ST_IDLE) && rst_n;

    dmem_rr_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (arb_en),
        .req_int   (i_req_valid),
        .req_fp    (f_req_valid),
        .grant_int (grant_int),
        .grant_fp  (grant_fp)
    );

    assign i_req_ready = grant_int;
    assign f_req_ready = grant_fp;
    assign busy        = (state != ST_IDLE);

    assign op_idx      = op_addr[IW+1:2];
    assign op_err      = (|(op_addr[1:0] & WORD_OFS_MASK)) || (|(op_addr >> (IW + 2)));
    assign access_done = (state == ST_ACCESS) && (lat_cnt == 3'd0);
    assign mem_we      = access_done && op_write && !op_err;
    assign rd_word     = (op_write || op_err) ? 32'd0 : mem[op_idx];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[op_idx] <= op_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            lat_cnt      <= 3'd0;
            op_write     <= 1'b0;
            op_port      <= PORT_INT;
            op_addr      <= 32'd0;
            op_wdata     <= 32'd0;
            i_resp_valid <= 1'b0;
            i_resp_rdata <= 32'd0;
            i_resp_err   <= 1'b0;
            f_resp_valid <= 1'b0;
            f_resp_rdata <= 32'd0;
            f_resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_int || grant_fp) begin
                        op_port  <= grant_fp ? PORT_FP : PORT_INT;
                        op_write <= grant_fp ? f_req_write : i_req_write;
                        op_addr  <= grant_fp ? f_req_addr : i_req_addr;
                        op_wdata <= grant_fp ? f_req_wdata : i_req_wdata;
                        lat_cnt  <= 3'(LATENCY - 1);
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (lat_cnt == 3'd0) begin
                        i_resp_valid <= (op_port == PORT_INT);
                        i_resp_rdata <= (op_port == PORT_INT) ? rd_word : 32'd0;
                        i_resp_err   <= (op_port == PORT_INT) && op_err;
                        f_resp_valid <= (op_port == PORT_FP);
                        f_resp_rdata <= (op_port == PORT_FP) ? rd_word : 32'd0;
                        f_resp_err   <= (op_port == PORT_FP) && op_err;
                        state        <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    i_resp_valid <= 1'b0;
                    i_resp_rdata <= 32'd0;
                    i_resp_err   <= 1'b0;
                    f_resp_valid <= 1'b0;
                    f_resp_rdata <= 32'd0;
                    f_resp_err   <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
